// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART core: data width, default FIFO read
// latency and the state encoding of the transmit drain sequencer.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Width of one UART character as held in the FIFO and the shifter.
    localparam int UART_DW = 8;

    // Default FIFO read latency: RAM read plus output register.
    localparam int RD_LAT_DEF = 2;

    // Drain sequencer states (3-bit encoding).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OFFER = 3'd3,
        ST_GAP   = 3'd4
    } drain_state_e;

endpackage

// File: rtl/uart_tx_drain_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_drain_ctrl
// Moves bytes from the transmit FIFO to the UART shifter. Issues one
// active-low read strobe per byte, waits out the FIFO read latency, offers
// the byte with valid/ready, then inserts a programmable idle gap. In flush
// mode bytes are read and dropped without being offered.
//
// Ports:
//   CLK, RESET_N     clock (rising edge) and async active-low reset
//   enable           drain the FIFO while high
//   flush            read and discard FIFO contents (overrides enable)
//   gap_cfg          idle cycles after each handshake, sampled on handshake
//   fifo_empty       FIFO empty flag
//   fifo_data        FIFO read data, valid RD_LAT edges after the strobe
//   fifo_rdb         registered active-low FIFO read strobe
//   tx_valid/tx_data byte offered to the transmitter
//   tx_ready         transmitter accept
//   busy             sequencer not idle
//   byte_cnt         bytes handed to the transmitter since reset (wraps)
// ---------------------------------------------------------------------------
module uart_tx_drain_ctrl
    import uart_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int GAP_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               enable,
    input  logic               flush,
    input  logic [GAP_W-1:0]   gap_cfg,
    input  logic               fifo_empty,
    input  logic [UART_DW-1:0] fifo_data,
    output logic               fifo_rdb,
    output logic               tx_valid,
    output logic [UART_DW-1:0] tx_data,
    input  logic               tx_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   byte_cnt
);

    // RD_LAT is at most 3, so the latency counter never exceeds 2.
    localparam int LAT_W = 2;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    drain_state_e       state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [UART_DW-1:0] tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               fifo_rdb_q, fifo_rdb_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, busy_d;

    // Start a fetch only when the FIFO has data; re-evaluated every time the
    // sequencer leaves IDLE, GAP or OFFER so an empty FIFO is never read.
    logic               start_ok;

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        byte_cnt_d = byte_cnt_q;
        start_ok   = (enable | flush) & ~fifo_empty;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_READ;
            end

            ST_READ: begin
                lat_d   = LAT_LOAD;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (lat_q == '0) begin
                    tx_data_d = fifo_data;
                    if (flush) begin
                        // Discarded byte: one GAP cycle with no idle gap.
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_OFFER;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            ST_OFFER: begin
                if (flush) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (tx_ready) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (gap_cfg == '0) begin
                        // Back-to-back: skip GAP and decide immediately.
                        gap_d   = '0;
                        state_d = start_ok ? ST_READ : ST_IDLE;
                    end else begin
                        gap_d   = gap_cfg;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                // The cycle where the counter reaches 0 also makes the
                // IDLE decision, so gap_cfg=N yields exactly N idle cycles.
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = start_ok ? ST_READ : ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so every
        // output (the read strobe in particular) comes straight from a flop.
        fifo_rdb_d = (state_d != ST_READ);
        tx_valid_d = (state_d == ST_OFFER);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            gap_q      <= '0;
            tx_data_q  <= '0;
            byte_cnt_q <= '0;
            fifo_rdb_q <= 1'b1;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            byte_cnt_q <= byte_cnt_d;
            fifo_rdb_q <= fifo_rdb_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_rdb = fifo_rdb_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_drain_ctrl
// Directed bench: a per-cycle vector table for the basic two-byte drain,
// then hand-written sequences for backpressure, gaps, flush, mid-operation
// reset and byte counter wrap (DUT built with CNT_W=4).
// ---------------------------------------------------------------------------
module tb_uart_tx_drain_ctrl;

    localparam int RD_LAT = 2;
    localparam int GAP_W  = 8;
    localparam int CNT_W  = 4;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b1;
    logic             enable, flush, tx_ready;
    logic [GAP_W-1:0] gap_cfg;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             fifo_rdb, tx_valid, busy;
    logic [7:0]       tx_data;
    logic [CNT_W-1:0] byte_cnt;

    always #5 CLK = ~CLK;

    uart_tx_drain_ctrl #(.RD_LAT(RD_LAT), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .enable     (enable),
        .flush      (flush),
        .gap_cfg    (gap_cfg),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rdb   (fifo_rdb),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .byte_cnt   (byte_cnt)
    );

    // ---------------- FIFO model: 16 deep, read latency 2 ----------------
    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] stage1;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Shares the reset net with the DUT: reset empties the FIFO.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr    <= wr_ptr;
            stage1    <= 8'h00;
            fifo_data <= 8'h00;
        end else begin
            if (!fifo_rdb && (rd_ptr != wr_ptr)) begin
                stage1 <= mem[rd_ptr % 16];
                rd_ptr <= rd_ptr + 1;
            end
            fifo_data <= stage1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         rd_cnt = 0;
    int         vld_cnt = 0;
    int         hs_cnt = 0;
    int         underflow = 0;
    int         rd_cyc [$];
    int         hs_cyc [$];
    logic [7:0] hs_dat [$];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!fifo_rdb) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc.push_back(cyc);
            if (fifo_empty) underflow <= underflow + 1;
        end
        if (tx_valid) vld_cnt <= vld_cnt + 1;
        if (tx_valid && tx_ready) begin
            hs_cnt <= hs_cnt + 1;
            hs_cyc.push_back(cyc);
            hs_dat.push_back(tx_data);
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             en;
        logic             fl;
        logic             rdy;
        logic [GAP_W-1:0] gap;
        logic             rdb;
        logic             vld;
        logic [7:0]       dat;
        logic             bsy;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic rdb, input logic vld, input logic [7:0] dat,
                                input logic bsy, input logic [CNT_W-1:0] cnt);
        vec_t v;
        v.en  = 1'b1;
        v.fl  = 1'b0;
        v.rdy = 1'b1;
        v.gap = '0;
        v.rdb = rdb;
        v.vld = vld;
        v.dat = dat;
        v.bsy = bsy;
        v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int h0;
        int r0;
        int v0;
        int bad_dat;
        logic hold_ok;

        // Two-byte drain, gap 0, ready high: one byte every RD_LAT+2 cycles.
        tbl[0] = mk(1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
        tbl[1] = mk(1'b1, 1'b0, 8'h00, 1'b1, 4'd0);
        tbl[2] = mk(1'b1, 1'b0, 8'h00, 1'b1, 4'd0);
        tbl[3] = mk(1'b1, 1'b1, 8'hA5, 1'b1, 4'd0);
        tbl[4] = mk(1'b0, 1'b0, 8'hA5, 1'b1, 4'd1);
        tbl[5] = mk(1'b1, 1'b0, 8'hA5, 1'b1, 4'd1);
        tbl[6] = mk(1'b1, 1'b0, 8'hA5, 1'b1, 4'd1);
        tbl[7] = mk(1'b1, 1'b1, 8'h3C, 1'b1, 4'd1);
        tbl[8] = mk(1'b1, 1'b0, 8'h3C, 1'b0, 4'd2);
        tbl[9] = mk(1'b1, 1'b0, 8'h3C, 1'b0, 4'd2);

        enable = 1'b0; flush = 1'b0; tx_ready = 1'b0; gap_cfg = '0;

        // Reset values, checked before any clock edge.
        #1 RESET_N = 1'b0;
        #2;
        chk("rst_rdb",  32'(fifo_rdb), 32'd1);
        chk("rst_vld",  32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data),  32'h00);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_cnt",  32'(byte_cnt), 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        push(8'hA5);
        push(8'h3C);

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            enable   = tbl[i].en;
            flush    = tbl[i].fl;
            tx_ready = tbl[i].rdy;
            gap_cfg  = tbl[i].gap;
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d rdb,vld,dat,bsy,cnt", i),
                32'({fifo_rdb, tx_valid, tx_data, busy, byte_cnt}),
                32'({tbl[i].rdb, tbl[i].vld, tbl[i].dat, tbl[i].bsy, tbl[i].cnt}));
        end

        // Backpressure: ready low for 10 valid cycles, then high.
        @(negedge CLK);
        tx_ready = 1'b0;
        push(8'h55);
        t = 0;
        while (!tx_valid && t < 20) begin @(negedge CLK); t++; end
        chk("bp_valid_seen", 32'(tx_valid), 32'd1);
        v0 = vld_cnt;
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!(tx_valid && tx_data == 8'h55 && byte_cnt == 4'd2)) hold_ok = 1'b0;
            @(negedge CLK);
        end
        chk("bp_hold_stable", 32'(hold_ok), 32'd1);
        tx_ready = 1'b1;
        @(negedge CLK);
        chk("bp_vld_drop", 32'(tx_valid), 32'd0);
        chk("bp_cnt", 32'(byte_cnt), 32'd3);
        chk("bp_vld_cycles", 32'(vld_cnt - v0), 32'd11);

        // Gap of 5 cycles between three bytes.
        gap_cfg = 8'd5;
        h0 = hs_cnt;
        r0 = rd_cnt;
        push(8'h11); push(8'h22); push(8'h33);
        t = 0;
        while (hs_cnt < h0 + 3 && t < 100) begin @(negedge CLK); t++; end
        chk("gap_hs_count", 32'(hs_cnt - h0), 32'd3);
        repeat (8) @(negedge CLK);
        chk("gap_d0", 32'(hs_dat[h0]),     32'h11);
        chk("gap_d1", 32'(hs_dat[h0 + 1]), 32'h22);
        chk("gap_d2", 32'(hs_dat[h0 + 2]), 32'h33);
        chk("gap_rd_after_hs0", 32'(rd_cyc[r0 + 1] - hs_cyc[h0]),     32'd6);
        chk("gap_rd_after_hs1", 32'(rd_cyc[r0 + 2] - hs_cyc[h0 + 1]), 32'd6);
        chk("gap_reads", 32'(rd_cnt - r0), 32'd3);
        chk("gap_cnt", 32'(byte_cnt), 32'd6);
        chk("gap_busy_end", 32'(busy), 32'd0);

        // Flush raised while a byte is being offered.
        gap_cfg = '0;
        tx_ready = 1'b0;
        h0 = hs_cnt;
        push(8'h66);
        t = 0;
        while (!tx_valid && t < 20) begin @(negedge CLK); t++; end
        chk("fo_valid_seen", 32'(tx_valid), 32'd1);
        flush = 1'b1;
        @(negedge CLK);
        chk("fo_vld_drop", 32'(tx_valid), 32'd0);
        chk("fo_cnt", 32'(byte_cnt), 32'd6);
        @(negedge CLK);
        chk("fo_busy_idle", 32'(busy), 32'd0);
        chk("fo_no_hs", 32'(hs_cnt - h0), 32'd0);

        // Flush four bytes with enable low: read and dropped, no gap applied.
        enable = 1'b0;
        tx_ready = 1'b1;
        gap_cfg = 8'd5;
        r0 = rd_cnt;
        v0 = vld_cnt;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        repeat (2) @(negedge CLK);
        t = 0;
        while ((!fifo_empty || busy) && t < 60) begin @(negedge CLK); t++; end
        chk("fl_idle_in_time", 32'(busy), 32'd0);
        chk("fl_reads", 32'(rd_cnt - r0), 32'd4);
        chk("fl_no_valid", 32'(vld_cnt - v0), 32'd0);
        chk("fl_cnt", 32'(byte_cnt), 32'd6);
        chk("fl_empty", 32'(fifo_empty), 32'd1);
        flush = 1'b0;

        // Reset pulse while waiting on the FIFO read latency.
        enable = 1'b1;
        gap_cfg = '0;
        push(8'h77);
        t = 0;
        while (fifo_rdb && t < 20) begin @(negedge CLK); t++; end
        chk("mr_read_seen", 32'(fifo_rdb), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        chk("mr_rdb",  32'(fifo_rdb), 32'd1);
        chk("mr_vld",  32'(tx_valid), 32'd0);
        chk("mr_cnt",  32'(byte_cnt), 32'd0);
        chk("mr_busy", 32'(busy),     32'd0);
        #1 RESET_N = 1'b1;
        @(negedge CLK);
        h0 = hs_cnt;
        r0 = rd_cnt;
        push(8'h9A);
        t = 0;
        while (hs_cnt < h0 + 1 && t < 30) begin @(negedge CLK); t++; end
        chk("mr_post_hs", 32'(hs_cnt - h0), 32'd1);
        chk("mr_post_data", 32'(hs_dat[h0]), 32'h9A);
        chk("mr_post_latency", 32'(hs_cyc[h0] - rd_cyc[r0]), 32'd3);
        chk("mr_post_cnt", 32'(byte_cnt), 32'd1);

        // Counter wrap: 14 more bytes reach 15, the next one wraps to 0.
        h0 = hs_cnt;
        for (int i = 0; i < 14; i++) push(8'(8'h80 + i));
        t = 0;
        while (hs_cnt < h0 + 14 && t < 200) begin @(negedge CLK); t++; end
        chk("wr_hs14", 32'(hs_cnt - h0), 32'd14);
        bad_dat = 0;
        for (int i = 0; i < 14; i++)
            if (hs_dat[h0 + i] != 8'(8'h80 + i)) bad_dat++;
        chk("wr_data14", 32'(bad_dat), 32'd0);
        chk("wr_cnt15", 32'(byte_cnt), 32'hF);
        h0 = hs_cnt;
        push(8'hC3);
        t = 0;
        while (hs_cnt < h0 + 1 && t < 30) begin @(negedge CLK); t++; end
        repeat (2) @(negedge CLK);
        chk("wr_cnt0", 32'(byte_cnt), 32'd0);
        chk("wr_data", 32'(hs_dat[h0]), 32'hC3);
        chk("wr_busy", 32'(busy), 32'd0);
        chk("no_underflow", 32'(underflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain_ctrl.md
Name: uart_tx_drain_ctrl

Overview:
Sequencer between the 16x8 transmit FIFO and the UART transmit shifter.
- Issues single-cycle active-low read strobes to the FIFO and waits out the FIFO's fixed read latency.
- Presents each byte to the transmitter with a valid/ready handshake.
- Enforces a programmable idle gap between bytes, supports a discard (flush) mode, and counts bytes sent.
- Sits inside the UART core, above the FIFO instance and below the APB register block that drives its configuration.

Parameters:
RD_LAT, 2, clock edges from the edge that samples fifo_rdb low to valid fifo_data (the FIFO's RAM read plus its output register); legal range 1..3.
GAP_W, 8, width of gap_cfg and of the internal gap counter.
CNT_W, 16, width of byte_cnt.

Ports:
CLK  in  1  single system clock, rising edge.
RESET_N  in  1  asynchronous, active-low reset.
enable  in  1  1 = drain the FIFO; 0 = finish the current byte, then idle.
flush  in  1  1 = read and discard FIFO contents, with no tx_valid.
gap_cfg  in  GAP_W  idle cycles inserted after each tx handshake; 0 = back-to-back.
fifo_empty  in  1  FIFO EMPTY flag.
fifo_data  in  8  FIFO read data.
fifo_rdb  out  1  active-low FIFO read strobe.
tx_valid  out  1  byte on tx_data is offered.
tx_data  out  8  byte to transmit.
tx_ready  in  1  transmitter accepts tx_data when tx_valid & tx_ready.
busy  out  1  state != IDLE.
byte_cnt  out  CNT_W  bytes handed to the transmitter since reset; wraps.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (CLK, RESET_N).
- Reset values (async, immediate on RESET_N low): fifo_rdb=1, tx_valid=0, tx_data=8'h00, busy=0, byte_cnt=0, state=IDLE, gap counter=0.
- Reset asserted mid-operation:
  - Any in-flight read is abandoned.
  - The FIFO is reset by the same net, so no resynchronisation is required.
- All outputs are registered.
- States: IDLE, READ, WAIT, OFFER, GAP.
- IDLE: if (enable | flush) & ~fifo_empty, go to READ; else stay.
- READ (exactly 1 cycle): fifo_rdb=0; latency counter loaded with RD_LAT-1; go to WAIT.
  - fifo_rdb is low only in READ, so there is never more than one outstanding read.
  - fifo_empty is re-sampled before every READ, so the controller never reads an empty FIFO.
- WAIT: count down the latency counter. At 0, capture fifo_data into tx_data, then:
  - flush high: discard the byte, go to GAP.
  - flush low: set tx_valid=1, go to OFFER.
  - The total from the READ edge to capture is RD_LAT edges.
- OFFER: hold tx_valid=1 and tx_data stable until tx_ready. On the handshake edge:
  - clear tx_valid;
  - increment byte_cnt (modulo 2^CNT_W);
  - load the gap counter with gap_cfg;
  - go to GAP.
  - tx_ready high in the first OFFER cycle means tx_valid lasts exactly one cycle.
  - tx_ready while tx_valid=0 is ignored.
- GAP: decrement the gap counter. When it reaches 0, apply the IDLE decision in the same cycle.
  - gap_cfg=0 gives READ directly after the handshake edge.
  - Steady-state throughput with gap_cfg=0 and tx_ready held high: one byte every RD_LAT+2 cycles.
  - After a flushed byte, the gap counter is 0 and gap_cfg is not applied.
- enable deasserted:
  - in OFFER: the byte still completes.
  - in READ/WAIT: the fetch completes and the byte is offered (no data loss).
- flush asserted during OFFER:
  - tx_valid drops next cycle;
  - the byte is discarded and not counted;
  - go to GAP with the counter at 0.
- Flush precedence: flush overrides enable. While flush is high, the FIFO is drained to empty, then the block idles.
- gap_cfg is sampled only on the handshake edge. Changing it mid-gap does not affect the current gap.
- No output glitches; fifo_rdb comes straight from a flop.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants for IDLE, READ, WAIT, OFFER, GAP (3-bit);
  - RD_LAT default;
  - the UART data width constant, 8.
- No sub-module: one FSM with three counters (latency, gap, byte_cnt) in a single file. Target roughly 150-250 lines of RTL.

Test Plan:
1. Reset, then preload FIFO model with 8'hA5, 8'h3C; enable=1, tx_ready=1, gap_cfg=0.
   -> fifo_rdb low exactly 1 cycle per byte; tx_data=A5 then 3C; tx_valid 1 cycle each, 4 cycles apart; byte_cnt=2; busy=0 after the last byte.
2. One byte 8'h55; tx_ready held low 10 cycles, then high.
   -> tx_valid held 11 cycles with tx_data stable at 55; byte_cnt increments once, on the accept edge.
3. gap_cfg=5, three bytes, tx_ready=1.
   -> 5 idle cycles after each handshake; next fifo_rdb low on the 6th cycle after the handshake edge; byte_cnt=3.
4. FIFO holds 4 bytes; flush=1, enable=0.
   -> four read strobes, tx_valid never high, byte_cnt unchanged, fifo_empty=1 at end; FSM returns to IDLE.
5. RESET_N pulsed low while in WAIT.
   -> fifo_rdb=1, tx_valid=0, byte_cnt=0, busy=0 asynchronously; the first post-reset byte follows the scenario-1 timing.
6. byte_cnt preset to 16'hFFFF via long run (or CNT_W=4 build, 16 bytes).
   -> wraps to 0 on the next handshake; no other effect on the FSM.
